// File: rtl/vid2is_av_st_output_pp.sv
// rtl/vid2is_av_st_output_pp.sv - Avalon-ST video output stage draining a read-latency-1 line FIFO
//
// Purpose : reads packet words {data, last} from the line FIFO, inserts a video
//           control packet ahead of a video packet when the active dims change
//           (or after reset / enable rising edge), and emits Avalon-ST video
//           with ready latency 0.
// Ports   : is_clk, rst (async, active-high)
//           enable, is_output_enable              run control
//           q, empty, rdreq                       line FIFO side
//           is_width, is_height, is_interlace,
//           is_dims_valid                         current active dimensions
//           is_ready, is_valid, is_data,
//           is_sop, is_eop                        Avalon-ST source
//           ctrl_sent                             pulse after a control packet eop is accepted
// Macro   : VID2IS_CTRL_EVERY_FRAME_EN - when defined, every video packet is
//           preceded by a control packet regardless of the dims comparison.

module vid2is_av_st_output_pp #(
    parameter int BPS                = 10,
    parameter int COLOUR_PLANES      = 2,
    parameter int PIXELS_IN_PARALLEL = 1,
    localparam int S                 = COLOUR_PLANES * PIXELS_IN_PARALLEL,
    localparam int DW                = S * BPS,
    localparam int CTRL_BEATS        = (9 + S - 1) / S
) (
    input  logic          is_clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW:0]   q,
    input  logic          empty,
    output logic          rdreq,
    input  logic [15:0]   is_width,
    input  logic [15:0]   is_height,
    input  logic [3:0]    is_interlace,
    input  logic          is_dims_valid,
    input  logic          is_ready,
    output logic          is_valid,
    output logic [DW-1:0] is_data,
    output logic          is_sop,
    output logic          is_eop,
    output logic          is_output_enable,
    output logic          ctrl_sent
);

    typedef enum logic [2:0] {IDLE, PKT_PEEK, CTRL_HDR, CTRL_BODY, PKT_BODY} state_t;

    state_t      state;
    logic [DW:0] sk0, sk1, sk0_nxt, sk1_nxt;
    logic [1:0]  sk_used, sk_used_nxt;
    logic        pending;          // a read was issued last cycle; its word is on q now
    logic [3:0]  ctrl_cnt;
    logic [35:0] last_dims;
    logic        force_ctrl;
    logic        enable_d;

    logic [35:0]   dims_cur;
    logic          head_valid;
    logic [DW:0]   head_word;
    logic [2:0]    fill;
    logic          out_free;
    logic          eop_done;
    logic          need_ctrl;
    logic          pop;
    logic [DW-1:0] ctrl_data;

    assign is_output_enable = enable | ~empty;
    assign dims_cur         = {is_width, is_height, is_interlace};

    // The head word is the oldest skid entry, or the word returning from the
    // FIFO this cycle when the skid is empty (bypass keeps throughput at one beat per cycle).
    assign head_valid = (sk_used != 2'd0) | pending;
    assign head_word  = (sk_used != 2'd0) ? sk0 : q;
    assign fill       = {1'b0, sk_used} + {2'b00, pending};
    assign out_free   = ~is_valid | is_ready;
    assign eop_done   = is_valid & is_eop & is_ready;

    // Words already held plus words in flight never exceed the two skid entries.
    assign rdreq = ~empty & (state != IDLE) & (fill < 3'd2);

`ifdef VID2IS_CTRL_EVERY_FRAME_EN
    assign need_ctrl = (head_word[4:1] == 4'h0) & is_dims_valid;
`else
    assign need_ctrl = (head_word[4:1] == 4'h0) & is_dims_valid &
                       (force_ctrl | (dims_cur != last_dims));
`endif

    always_comb begin
        pop = 1'b0;
        case (state)
            PKT_PEEK:  pop = head_valid & out_free & ~need_ctrl;
            CTRL_BODY: pop = eop_done;
            PKT_BODY:  pop = head_valid & out_free & ~(is_valid & is_eop);
            default:   pop = 1'b0;
        endcase
    end

    always_comb begin
        sk0_nxt     = sk0;
        sk1_nxt     = sk1;
        sk_used_nxt = sk_used;
        if (pop && (sk_used != 2'd0)) begin
            sk0_nxt     = sk1;
            sk_used_nxt = sk_used - 2'd1;
        end
        if (pending && !(pop && (sk_used == 2'd0))) begin
            if (sk_used_nxt == 2'd0)
                sk0_nxt = q;
            else
                sk1_nxt = q;
            sk_used_nxt = sk_used_nxt + 2'd1;
        end
    end

    // Control body beat: symbol j of beat n carries dims nibble n*S+j.
    always_comb begin
        logic [35:0] sh;
        int          idx;
        ctrl_data = '0;
        sh        = '0;
        idx       = 0;
        for (int j = 0; j < S; j++) begin
            idx = int'(ctrl_cnt) * S + j;
            if (idx < 9) begin
                sh = dims_cur >> (4 * (8 - idx));
                ctrl_data[j*BPS +: 4] = sh[3:0];
            end
        end
    end

    always_ff @(posedge is_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sk0        <= '0;
            sk1        <= '0;
            sk_used    <= 2'd0;
            pending    <= 1'b0;
            ctrl_cnt   <= 4'd0;
            last_dims  <= '0;
            force_ctrl <= 1'b1;
            enable_d   <= 1'b0;
            is_valid   <= 1'b0;
            is_data    <= '0;
            is_sop     <= 1'b0;
            is_eop     <= 1'b0;
            ctrl_sent  <= 1'b0;
        end else begin
            pending   <= rdreq;
            enable_d  <= enable;
            ctrl_sent <= 1'b0;
            sk0       <= sk0_nxt;
            sk1       <= sk1_nxt;
            sk_used   <= sk_used_nxt;
            if (is_valid && is_ready)
                is_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if ((is_output_enable && !empty) || head_valid)
                        state <= PKT_PEEK;
                end
                PKT_PEEK: begin
                    if (head_valid) begin
                        if (need_ctrl) begin
                            state <= CTRL_HDR;
                        end else if (out_free) begin
                            is_valid <= 1'b1;
                            is_data  <= head_word[DW:1];
                            is_sop   <= 1'b1;
                            is_eop   <= head_word[0];
                            state    <= PKT_BODY;
                        end
                    end
                end
                CTRL_HDR: begin
                    if (out_free) begin
                        is_valid <= 1'b1;
                        is_data  <= {{(DW-4){1'b0}}, 4'hF};
                        is_sop   <= 1'b1;
                        is_eop   <= 1'b0;
                        ctrl_cnt <= 4'd0;
                        state    <= CTRL_BODY;
                    end
                end
                CTRL_BODY: begin
                    if (eop_done) begin
                        // Control packet done: release the held video header.
                        last_dims  <= dims_cur;
                        force_ctrl <= 1'b0;
                        ctrl_sent  <= 1'b1;
                        is_valid   <= 1'b1;
                        is_data    <= head_word[DW:1];
                        is_sop     <= 1'b1;
                        is_eop     <= head_word[0];
                        state      <= PKT_BODY;
                    end else if (out_free) begin
                        is_valid <= 1'b1;
                        is_data  <= ctrl_data;
                        is_sop   <= 1'b0;
                        is_eop   <= (ctrl_cnt == 4'(CTRL_BEATS - 1));
                        ctrl_cnt <= ctrl_cnt + 4'd1;
                    end
                end
                PKT_BODY: begin
                    if (is_valid && is_eop) begin
                        if (is_ready)
                            state <= is_output_enable ? PKT_PEEK : IDLE;
                    end else if (out_free && head_valid) begin
                        is_valid <= 1'b1;
                        is_data  <= head_word[DW:1];
                        is_sop   <= 1'b0;
                        is_eop   <= head_word[0];
                    end
                end
                default: state <= IDLE;
            endcase

            if (enable && !enable_d)
                force_ctrl <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vid2is_av_st_output_pp.sv
// tb/tb_vid2is_av_st_output_pp.sv - self-checking bench for vid2is_av_st_output_pp

module tb_vid2is_av_st_output_pp;

    localparam int BPS = 10;
    localparam int S   = 2;
    localparam int DW  = S * BPS;

    logic          is_clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW:0]   q = '0;
    logic          empty;
    logic          rdreq;
    logic [15:0]   is_width;
    logic [15:0]   is_height;
    logic [3:0]    is_interlace;
    logic          is_dims_valid;
    logic          is_ready;
    logic          is_valid;
    logic [DW-1:0] is_data;
    logic          is_sop;
    logic          is_eop;
    logic          is_output_enable;
    logic          ctrl_sent;

    vid2is_av_st_output_pp #(
        .BPS(BPS), .COLOUR_PLANES(2), .PIXELS_IN_PARALLEL(1)
    ) dut (
        .is_clk(is_clk), .rst(rst), .enable(enable), .q(q), .empty(empty),
        .rdreq(rdreq), .is_width(is_width), .is_height(is_height),
        .is_interlace(is_interlace), .is_dims_valid(is_dims_valid),
        .is_ready(is_ready), .is_valid(is_valid), .is_data(is_data),
        .is_sop(is_sop), .is_eop(is_eop), .is_output_enable(is_output_enable),
        .ctrl_sent(ctrl_sent)
    );

    always #5 is_clk = ~is_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Line FIFO model, read latency 1.
    logic [DW:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int ovr_err = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge is_clk) begin
        if (rdreq) begin
            if (wr_ptr == rd_ptr) ovr_err++;
            else begin
                q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    int rdy_mode = 0;
    always @(posedge is_clk) begin
        #1;
        if (rdy_mode == 1) is_ready = ~is_ready;
        else is_ready = 1'b1;
    end

    // Beat monitor, sampled mid-cycle.
    logic [DW-1:0] mon_data[$];
    bit            mon_sop[$];
    bit            mon_eop[$];
    int            ctrl_pulses = 0;
    int            hold_err = 0;
    logic          pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
    logic [DW-1:0] pd = '0;

    always @(negedge is_clk) begin
        if (!rst) begin
            if (pv && !pr && (!is_valid || is_data != pd || is_sop != ps || is_eop != pe))
                hold_err++;
            if (is_valid && is_ready) begin
                mon_data.push_back(is_data);
                mon_sop.push_back(is_sop);
                mon_eop.push_back(is_eop);
            end
            if (ctrl_sent) ctrl_pulses++;
        end
        pv = is_valid && !rst;
        pr = is_ready;
        pd = is_data;
        ps = is_sop;
        pe = is_eop;
    end

    task automatic chk(input logic ok, input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  il;
        logic [3:0]  ptype;
        int          nwords;
        int          rdy;
        logic        en_pulse;
        logic        exp_ctrl;
        logic [35:0] exp_nib;   // nine hand-written nibbles, first one leftmost
    } vec_t;

    vec_t tbl[9];

    task automatic push_word(input logic [DW-1:0] d, input logic last);
        mem[wr_ptr] = {d, last};
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [DW-1:0] word_data(input int id, input int k, input logic [3:0] ptype);
        logic [DW-1:0] d;
        if (k == 0) begin
            d = '0;
            d[3:0]   = ptype;
            d[9:4]   = 6'(id);
            d[19:10] = 10'(341 + id);
        end else begin
            d = 20'(id * 4096 + k * 37 + 1);
        end
        return d;
    endfunction

    task automatic run_case(input vec_t v, input int id);
        logic [DW-1:0] exp_d[$];
        bit            exp_s[$];
        bit            exp_e[$];
        logic [DW-1:0] d;
        logic [35:0]   sh;
        int            t;
        @(posedge is_clk); #1;
        is_width     = v.w;
        is_height    = v.h;
        is_interlace = v.il;
        if (v.en_pulse) begin
            enable = 1'b0;
            repeat (3) @(posedge is_clk);
            #1;
            chk(is_output_enable == 1'b0, $sformatf("case%0d output_enable_low", id), 64'(is_output_enable), 64'd0);
            enable = 1'b1;
            @(posedge is_clk); #1;
        end
        mon_data.delete(); mon_sop.delete(); mon_eop.delete();
        ctrl_pulses = 0;
        rdy_mode = v.rdy;
        if (v.exp_ctrl) begin
            exp_d.push_back(20'h0000F); exp_s.push_back(1'b1); exp_e.push_back(1'b0);
            for (int b = 0; b < 5; b++) begin
                d = '0;
                sh = v.exp_nib >> (32 - 8 * b);
                d[3:0] = sh[3:0];
                if (2 * b + 1 < 9) begin
                    sh = v.exp_nib >> (28 - 8 * b);
                    d[13:10] = sh[3:0];
                end
                exp_d.push_back(d); exp_s.push_back(1'b0); exp_e.push_back(b == 4);
            end
        end
        for (int k = 0; k < v.nwords; k++) begin
            d = word_data(id, k, v.ptype);
            push_word(d, k == v.nwords - 1);
            exp_d.push_back(d); exp_s.push_back(k == 0); exp_e.push_back(k == v.nwords - 1);
        end
        t = 0;
        while (mon_data.size() < exp_d.size() && t < 500) begin
            @(posedge is_clk);
            t++;
        end
        repeat (10) @(posedge is_clk);
        #1;
        rdy_mode = 0;
        chk(mon_data.size() == exp_d.size(), $sformatf("case%0d beat_count", id), 64'(mon_data.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < mon_data.size())
                chk(mon_data[i] == exp_d[i] && mon_sop[i] == exp_s[i] && mon_eop[i] == exp_e[i],
                    $sformatf("case%0d beat%0d {data,sop,eop}", id, i),
                    64'({mon_data[i], mon_sop[i], mon_eop[i]}), 64'({exp_d[i], exp_s[i], exp_e[i]}));
        end
        chk(ctrl_pulses == int'(v.exp_ctrl), $sformatf("case%0d ctrl_sent_pulses", id), 64'(ctrl_pulses), 64'(v.exp_ctrl));
    endtask

    initial begin
        int t;
        rst = 1'b1; enable = 1'b0; is_ready = 1'b1;
        is_width = '0; is_height = '0; is_interlace = '0; is_dims_valid = 1'b0;

        //          w        h        il    type  n   rdy en    ctrl  nibbles
        tbl[0] = '{16'd720,  16'd480, 4'd0, 4'd0, 3,  0,  1'b0, 1'b1, 36'h02D001E00};
        tbl[1] = '{16'd720,  16'd480, 4'd0, 4'd0, 3,  0,  1'b0, 1'b0, 36'h0};
        tbl[2] = '{16'd1280, 16'd720, 4'd0, 4'd0, 3,  0,  1'b0, 1'b1, 36'h050002D00};
        tbl[3] = '{16'd640,  16'd480, 4'd0, 4'd4, 2,  0,  1'b0, 1'b0, 36'h0};
        tbl[4] = '{16'd1280, 16'd720, 4'd0, 4'd0, 16, 1,  1'b0, 1'b0, 36'h0};
        tbl[5] = '{16'd1280, 16'd720, 4'd0, 4'd0, 1,  0,  1'b0, 1'b0, 36'h0};
        tbl[6] = '{16'h1234, 16'h0ABC, 4'd5, 4'd0, 2, 1,  1'b0, 1'b1, 36'h12340ABC5};
        tbl[7] = '{16'h1234, 16'h0ABC, 4'd5, 4'd0, 2, 0,  1'b1, 1'b1, 36'h12340ABC5};
        tbl[8] = '{16'h1234, 16'h0ABC, 4'd5, 4'd0, 3, 0,  1'b0, 1'b1, 36'h12340ABC5};

        #2;
        chk(is_valid == 1'b0, "reset is_valid", 64'(is_valid), 64'd0);
        chk(is_data == '0, "reset is_data", 64'(is_data), 64'd0);
        chk(is_sop == 1'b0 && is_eop == 1'b0, "reset sop_eop", 64'({is_sop, is_eop}), 64'd0);
        chk(rdreq == 1'b0 && ctrl_sent == 1'b0, "reset rdreq_ctrl_sent", 64'({rdreq, ctrl_sent}), 64'd0);
        chk(is_output_enable == 1'b0, "reset output_enable", 64'(is_output_enable), 64'd0);

        repeat (3) @(posedge is_clk);
        #1;
        rst = 1'b0;
        enable = 1'b1;
        is_dims_valid = 1'b1;
        #1;
        chk(is_output_enable == 1'b1, "enable output_enable", 64'(is_output_enable), 64'd1);

        for (int i = 0; i < 8; i++) run_case(tbl[i], i);

        // Reset in the middle of a 16-word packet body.
        @(posedge is_clk); #1;
        mon_data.delete(); mon_sop.delete(); mon_eop.delete();
        for (int k = 0; k < 16; k++) push_word(word_data(9, k, 4'd0), k == 15);
        t = 0;
        while (mon_data.size() < 4 && t < 300) begin
            @(posedge is_clk);
            t++;
        end
        chk(mon_data.size() >= 4, "midbody beats before reset", 64'(mon_data.size()), 64'd4);
        @(negedge is_clk);
        rst = 1'b1;
        #1;
        chk(is_valid == 1'b0 && is_sop == 1'b0 && is_eop == 1'b0, "midreset valid_sop_eop",
            64'({is_valid, is_sop, is_eop}), 64'd0);
        chk(is_data == '0 && rdreq == 1'b0 && ctrl_sent == 1'b0, "midreset data_rdreq",
            64'({is_data, rdreq, ctrl_sent}), 64'd0);
        @(posedge is_clk); #1;
        wr_ptr = rd_ptr;
        chk(is_valid == 1'b0, "midreset held is_valid", 64'(is_valid), 64'd0);
        repeat (2) @(posedge is_clk);
        #1;
        rst = 1'b0;
        run_case(tbl[8], 8);

        chk(hold_err == 0, "beats held while not ready", 64'(hold_err), 64'd0);
        chk(ovr_err == 0, "fifo overrun reads", 64'(ovr_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
